// File: rtl/infer_sequencer.sv
// -----------------------------------------------------------------------------
// infer_sequencer
// Sequences one inference through N_STAGES datapath stages. An input vector is
// accepted by valid/ready and held in x_hold for the datapath. Each stage gets
// a one-cycle start pulse, spaced by a runtime-programmable latency table. The
// final datapath result is captured into y_out behind a valid/ready output.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready input handshake, x_in input vector, x_hold held copy
//   stage_start       one-cycle start pulse per datapath stage
//   y_result          final datapath output, sampled at the end of the run
//   out_valid/out_ready/y_out  captured result with back-pressure
//   lat_wr_en/idx/data  latency table write port, lat_wr_err rejected write
//   busy              inference in flight
//   done_flag         one-cycle pulse when y_out is loaded
//   debug_cc          cycles since last accept, saturating
// Requires N_STAGES >= 2.
// -----------------------------------------------------------------------------
module infer_sequencer #(
    parameter int unsigned BITSIZE  = 16,
    parameter int unsigned N_IN     = 10,
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned N_STAGES = 4,
    parameter int unsigned CNT_W    = 8,
    parameter logic [N_STAGES*CNT_W-1:0] LAT_INIT = {N_STAGES{8'd8}}
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BITSIZE*N_IN-1:0]       x_in,
    output logic [BITSIZE*N_IN-1:0]       x_hold,
    output logic [N_STAGES-1:0]           stage_start,
    input  logic [BITSIZE*N_OUT-1:0]      y_result,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BITSIZE*N_OUT-1:0]      y_out,
    input  logic                          lat_wr_en,
    input  logic [$clog2(N_STAGES)-1:0]   lat_wr_idx,
    input  logic [CNT_W-1:0]              lat_wr_data,
    output logic                          lat_wr_err,
    output logic                          busy,
    output logic                          done_flag,
    output logic [15:0]                   debug_cc
);

    localparam int unsigned IDX_W = $clog2(N_STAGES);
    localparam int unsigned X_W   = BITSIZE * N_IN;
    localparam int unsigned Y_W   = BITSIZE * N_OUT;
    localparam int unsigned DBG_W = 16;
    localparam logic [IDX_W-1:0] LAST_STG = IDX_W'(N_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       stg_q, stg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       lat_q   [N_STAGES];
    logic [CNT_W-1:0]       lat_new [N_STAGES];
    logic [N_STAGES-1:0]    stage_start_d;
    logic                   capture_c;
    logic                   accept_c;
    logic                   slot_free_c;
    logic                   idx_ok_c;
    logic                   wr_ok_c;
    logic                   run_end_c;
    logic [IDX_W-1:0]       nxt_stg_c;
    logic                   started_q;

    // Zero latency is treated as one cycle.
    function automatic logic [CNT_W-1:0] eff_lat(input logic [CNT_W-1:0] l);
        return (l == '0) ? CNT_W'(1) : l;
    endfunction

    // Countdown preload: intermediate stages expire one cycle early so the next
    // start pulse (registered) lands exactly L cycles later; the last stage
    // expires on the cycle y_result is sampled.
    function automatic logic [CNT_W-1:0] load_cnt(input logic [CNT_W-1:0] l,
                                                  input logic             last);
        return last ? eff_lat(l) : (eff_lat(l) - CNT_W'(1));
    endfunction

    assign accept_c    = in_valid && in_ready;
    assign slot_free_c = !out_valid || out_ready;
    assign idx_ok_c    = ({1'b0, lat_wr_idx} < (IDX_W + 1)'(N_STAGES));
    assign wr_ok_c     = lat_wr_en && (state_q == IDLE) && idx_ok_c;
    assign run_end_c   = (state_q == RUN) && (cnt_q == '0) && (stg_q == LAST_STG);
    assign nxt_stg_c   = stg_q + IDX_W'(1);

    // Latency table view including a write landing this cycle, so a write that
    // coincides with an accept already applies to that inference.
    always_comb begin
        for (int k = 0; k < N_STAGES; k++) begin
            lat_new[k] = (wr_ok_c && (lat_wr_idx == IDX_W'(k))) ? lat_wr_data : lat_q[k];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (run_end_c) begin
                    state_d = slot_free_c ? IDLE : WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / sequencing logic: next start pulse, stage counter, capture.
    always_comb begin
        stage_start_d = '0;
        capture_c     = 1'b0;
        stg_d         = stg_q;
        cnt_d         = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    stage_start_d[0] = 1'b1;
                    stg_d            = '0;
                    cnt_d            = load_cnt(lat_new[0], 1'b0);
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (stg_q == LAST_STG) begin
                    capture_c = slot_free_c;
                end else begin
                    stage_start_d[nxt_stg_c] = 1'b1;
                    stg_d                    = nxt_stg_c;
                    cnt_d                    = load_cnt(lat_q[nxt_stg_c], nxt_stg_c == LAST_STG);
                end
            end
            WAIT_OUT: begin
                capture_c = out_ready;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_q       <= '0;
            cnt_q       <= '0;
            stage_start <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            x_hold      <= '0;
            y_out       <= '0;
            out_valid   <= 1'b0;
            done_flag   <= 1'b0;
            lat_wr_err  <= 1'b0;
            debug_cc    <= '0;
            started_q   <= 1'b0;
            for (int k = 0; k < N_STAGES; k++) begin
                lat_q[k] <= LAT_INIT[CNT_W*k +: CNT_W];
            end
        end else begin
            stg_q       <= stg_d;
            cnt_q       <= cnt_d;
            stage_start <= stage_start_d;
            in_ready    <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            lat_wr_err  <= lat_wr_en && !wr_ok_c;
            done_flag   <= capture_c;
            for (int k = 0; k < N_STAGES; k++) begin
                lat_q[k] <= lat_new[k];
            end
            if (accept_c) begin
                x_hold <= X_W'(x_in);
            end
            // A capture on the same edge as a consume keeps out_valid high.
            if (capture_c) begin
                y_out     <= Y_W'(y_result);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept_c) begin
                debug_cc  <= '0;
                started_q <= 1'b1;
            end else if (started_q && (debug_cc != {DBG_W{1'b1}})) begin
                debug_cc <= debug_cc + DBG_W'(1);
            end
        end
    end

    // Start pulses never overlap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0(stage_start))
                else $error("stage_start not one-hot: %b", stage_start);
        end
    end

endmodule

// File: tb/tb_infer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_infer_sequencer
// Directed vectors for infer_sequencer: a table of latency programs with
// hand-computed stage_start / out_valid cycles, plus hand-written sequences for
// mid-run reset, output back-pressure, back-to-back accepts and a rejected
// out-of-range latency write (on a 3-stage instance).
// Cycle 0 is the cycle whose ending edge accepts the input.
// -----------------------------------------------------------------------------
module tb_infer_sequencer;

    localparam int unsigned X_W = 160;
    localparam int unsigned Y_W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid, in_ready;
    logic [X_W-1:0] x_in, x_hold;
    logic [3:0]     stage_start;
    logic [Y_W-1:0] y_result, y_out;
    logic           out_valid, out_ready;
    logic           lat_wr_en;
    logic [1:0]     lat_wr_idx;
    logic [7:0]     lat_wr_data;
    logic           lat_wr_err, busy, done_flag;
    logic [15:0]    debug_cc;

    // 3-stage instance: index 3 is out of range there.
    logic           in_valid3, in_ready3, out_valid3, lat_wr_en3, lat_wr_err3;
    logic           busy3, done_flag3;
    logic [X_W-1:0] x_hold3;
    logic [2:0]     stage_start3;
    logic [Y_W-1:0] y_out3;
    logic [15:0]    debug_cc3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    infer_sequencer u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .x_hold(x_hold), .stage_start(stage_start),
        .y_result(y_result), .out_valid(out_valid), .out_ready(out_ready),
        .y_out(y_out), .lat_wr_en(lat_wr_en), .lat_wr_idx(lat_wr_idx),
        .lat_wr_data(lat_wr_data), .lat_wr_err(lat_wr_err), .busy(busy),
        .done_flag(done_flag), .debug_cc(debug_cc)
    );

    infer_sequencer #(.N_STAGES(3), .LAT_INIT({3{8'd8}})) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .x_in(x_in), .x_hold(x_hold3), .stage_start(stage_start3),
        .y_result(y_result), .out_valid(out_valid3), .out_ready(out_ready),
        .y_out(y_out3), .lat_wr_en(lat_wr_en3), .lat_wr_idx(lat_wr_idx),
        .lat_wr_data(lat_wr_data), .lat_wr_err(lat_wr_err3), .busy(busy3),
        .done_flag(done_flag3), .debug_cc(debug_cc3)
    );

    typedef struct {
        bit             prog;     // program lats before/at accept
        logic [31:0]    lats;     // stage k latency at [8k+:8]
        logic [31:0]    starts;   // expected stage k start cycle at [8k+:8]
        int             out_cyc;  // expected first out_valid cycle
        int             bad_cyc;  // cycle to issue an illegal write (0 = none)
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [X_W-1:0] act, input logic [X_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {stage_start, out_valid, done_flag, busy, in_ready, lat_wr_err}
    function automatic logic [8:0] status();
        return {stage_start, out_valid, done_flag, busy, in_ready, lat_wr_err};
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [3:0] ss_e;
        logic [8:0] exp;
        if (v.prog) begin
            for (int k = 0; k < 3; k++) begin
                lat_wr_en = 1'b1; lat_wr_idx = 2'(k); lat_wr_data = v.lats[8*k +: 8];
                @(posedge clk); @(negedge clk);
                lat_wr_en = 1'b0;
                chk($sformatf("v%0d_wr%0d_err", id, k), X_W'(lat_wr_err), X_W'(0));
            end
        end
        // Accept; the last latency write (if any) lands on the accept edge.
        in_valid = 1'b1; x_in = v.x; y_result = v.y;
        lat_wr_en = v.prog; lat_wr_idx = 2'd3; lat_wr_data = v.lats[31:24];
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= v.out_cyc + 1; c++) begin
            in_valid = 1'b0; lat_wr_en = 1'b0; x_in = ~v.x;
            if (v.bad_cyc != 0 && c == v.bad_cyc) begin
                lat_wr_en = 1'b1; lat_wr_idx = 2'd0; lat_wr_data = 8'd1;
            end
            ss_e = '0;
            for (int k = 0; k < 4; k++) begin
                if (c == int'(v.starts[8*k +: 8])) ss_e[k] = 1'b1;
            end
            exp = {ss_e, c == v.out_cyc, c == v.out_cyc, c < v.out_cyc, c >= v.out_cyc,
                   v.bad_cyc != 0 && c == v.bad_cyc + 1};
            chk($sformatf("v%0d_c%0d_status", id, c), X_W'(status()), X_W'(exp));
            if (c == v.out_cyc) begin
                chk($sformatf("v%0d_y_out", id), X_W'(y_out), X_W'(v.y));
                chk($sformatf("v%0d_x_hold", id), x_hold, v.x);
                chk($sformatf("v%0d_debug_cc", id), X_W'(debug_cc), X_W'(v.out_cyc - 1));
            end
            if (c <= v.out_cyc) @(negedge clk);
        end
        lat_wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0; x_in = '0; y_result = '0;
        out_ready = 1'b1; lat_wr_en = 1'b0; lat_wr_en3 = 1'b0; lat_wr_idx = '0; lat_wr_data = '0;

        vecs[0] = '{1'b0, 32'h08080808, {8'd25, 8'd17, 8'd9, 8'd1}, 34, 3, {5{32'hA5A5_0001}}, 32'h1111_2222};
        vecs[1] = '{1'b0, 32'h08080808, {8'd25, 8'd17, 8'd9, 8'd1}, 34, 0, {5{32'h0F0F_0002}}, 32'h3333_4444};
        vecs[2] = '{1'b1, {8'd0, 8'd3, 8'd2, 8'd1}, {8'd7, 8'd4, 8'd2, 8'd1}, 9, 0, {5{32'h1234_0003}}, 32'h5555_6666};
        vecs[3] = '{1'b1, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd4, 8'd3, 8'd2, 8'd1}, 6, 0, {5{32'hCAFE_0004}}, 32'h7777_8888};
        vecs[4] = '{1'b1, {8'd5, 8'd1, 8'd1, 8'd2}, {8'd5, 8'd4, 8'd3, 8'd1}, 11, 0, {5{32'hBEEF_0005}}, 32'h9999_AAAA};
        vecs[5] = '{1'b0, 32'h08080808, {8'd25, 8'd17, 8'd9, 8'd1}, 34, 0, {5{32'hD00D_0006}}, 32'hBBBB_CCCC};

        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        // Reset state.
        chk("rst_status", X_W'(status()), X_W'(9'b0000_0001_0));
        chk("rst_x_hold", x_hold, '0);
        chk("rst_y_out", X_W'(y_out), '0);
        chk("rst_debug_cc", X_W'(debug_cc), '0);

        // Out-of-range index on the 3-stage instance.
        lat_wr_en3 = 1'b1; lat_wr_idx = 2'd3; lat_wr_data = 8'd1;
        @(posedge clk); @(negedge clk);
        lat_wr_en3 = 1'b0;
        chk("idx_oor_err", X_W'(lat_wr_err3), X_W'(1));
        @(posedge clk); @(negedge clk);
        chk("idx_oor_err_pulse", X_W'(lat_wr_err3), X_W'(0));
        in_valid3 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid3 = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            if (c >= 24) chk($sformatf("dut3_c%0d_out_valid", c), X_W'(out_valid3), X_W'(c == 26));
            if (c == 9) chk("dut3_start1", X_W'(stage_start3), X_W'(3'b010));
            if (c < 26) @(negedge clk);
        end

        for (int i = 0; i < 2; i++) run_vec(vecs[i], i);

        // Reset at cycle 12 of a default run aborts it.
        in_valid = 1'b1; x_in = {5{32'h5151_5151}}; y_result = 32'hDEAD_0000;
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            in_valid = 1'b0;
            if (c == 12) reset = 1'b1;
            if (c == 13) begin
                reset = 1'b0;
                chk("midrst_status", X_W'(status()), X_W'(9'b0000_0001_0));
                chk("midrst_y_out", X_W'(y_out), '0);
                chk("midrst_x_hold", x_hold, '0);
            end
            if (c > 13) chk($sformatf("midrst_c%0d_quiet", c), X_W'({stage_start, out_valid}), '0);
            @(negedge clk);
        end

        for (int i = 2; i < 5; i++) run_vec(vecs[i], i);

        // Reset restores LAT_INIT (table was {2,1,1,5}).
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[5], 5);

        // Back-pressure across two inferences.
        out_ready = 1'b0; in_valid = 1'b1; x_in = {5{32'hAAAA_0000}}; y_result = 32'h0A0A_0A0A;
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= 75; c++) begin
            case (c)
                34: begin
                    chk("bp_a_status", X_W'({out_valid, done_flag, in_ready}), X_W'(3'b111));
                    chk("bp_a_y_out", X_W'(y_out), X_W'(32'h0A0A_0A0A));
                    x_in = {5{32'hBBBB_0000}}; y_result = 32'h0B0B_0B0B;
                end
                35: begin
                    in_valid = 1'b0;
                    chk("bp_b_accept", X_W'({busy, in_ready, stage_start}), X_W'(6'b10_0001));
                    chk("bp_b_x_hold", x_hold, {5{32'hBBBB_0000}});
                end
                68, 72: begin
                    chk($sformatf("bp_wait_c%0d", c), X_W'(status()), X_W'(9'b0000_1_0_1_0_0));
                    chk($sformatf("bp_wait_y_c%0d", c), X_W'(y_out), X_W'(32'h0A0A_0A0A));
                    if (c == 72) out_ready = 1'b1;
                end
                73: begin
                    chk("bp_b_load", X_W'(status()), X_W'(9'b0000_1_1_0_1_0));
                    chk("bp_b_y_out", X_W'(y_out), X_W'(32'h0B0B_0B0B));
                    out_ready = 1'b0;
                end
                74: begin
                    chk("bp_hold", X_W'({out_valid, done_flag}), X_W'(2'b10));
                    chk("bp_hold_y", X_W'(y_out), X_W'(32'h0B0B_0B0B));
                    out_ready = 1'b1;
                end
                75: chk("bp_drain", X_W'(out_valid), X_W'(0));
                default: ;
            endcase
            if (c < 75) @(negedge clk);
        end

        // Back-to-back accepts with in_valid held high.
        out_ready = 1'b1; in_valid = 1'b1; x_in = {5{32'hC0C0_0000}};
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= 103; c++) begin
            x_in = {5{32'hC0C0_0000}} + X_W'(c);
            case (c)
                20: chk("b2b_hold_a", x_hold, {5{32'hC0C0_0000}});
                34: chk("b2b_c34", X_W'({out_valid, in_ready}), X_W'(2'b11));
                35: begin
                    chk("b2b_c35", X_W'({in_ready, stage_start}), X_W'(5'b0_0001));
                    chk("b2b_hold_b", x_hold, {5{32'hC0C0_0000}} + X_W'(34));
                end
                68: chk("b2b_c68", X_W'({out_valid, done_flag, in_ready}), X_W'(3'b111));
                69: begin
                    in_valid = 1'b0;
                    chk("b2b_hold_c", x_hold, {5{32'hC0C0_0000}} + X_W'(68));
                end
                101: chk("b2b_c101", X_W'(out_valid), X_W'(0));
                102: chk("b2b_c102", X_W'(out_valid), X_W'(1));
                default: ;
            endcase
            if (c < 103) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
